// File: rtl/dmem_responder.sv
// Data-memory responder for the Riscv151 data port: byte-masked word RAM, aligned
// sign/zero-extended loads with one cycle of latency, and MMIO cycle/retire counters.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [1:0]  st_size,
    input  logic [2:0]  ld_size,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic        misaligned
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_CNT
    } region_e;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           ram_word_q;

    logic        is_ram;
    logic        hit_cycle;
    logic        hit_retire;
    logic        hit_clear;
    logic        st_mis;
    logic        st_ok;
    logic        ram_we;
    logic        clear_cnt;
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;

    logic [31:0] cycle_cnt_q,  cycle_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        ld_valid_q,   ld_valid_d;
    region_e     region_q,     region_d;
    logic [1:0]  offset_q,     offset_d;
    logic        st_mis_q,     st_mis_d;
    logic [31:0] cnt_val_q,    cnt_val_d;

    assign word_idx = req_addr[DEPTH_LOG2+1:2];

    always_comb begin
        is_ram     = ~req_addr[31];
        hit_cycle  = (req_addr == MMIO_BASE);
        hit_retire = (req_addr == MMIO_BASE + 32'd4);
        hit_clear  = (req_addr == MMIO_BASE + 32'd8);

        st_mis = 1'b0;
        case (st_size)
            2'b01:   st_mis = req_addr[0];
            2'b10:   st_mis = |req_addr[1:0];
            default: st_mis = 1'b0;
        endcase

        // Reserved store size behaves like no store at all, so it is neither written nor flagged.
        st_ok     = req_we & ~st_mis & (st_size != 2'b11);
        ram_we    = st_ok & is_ram & reset;
        clear_cnt = st_ok & hit_clear;

        byte_en  = 4'b0000;
        wr_lanes = req_wdata;
        case (st_size)
            2'b00: begin
                byte_en  = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = 4'b0011 << req_addr[1:0];
                wr_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                wr_lanes = req_wdata;
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = req_wdata;
            end
        endcase
    end

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + 32'd1;
        retire_cnt_d = retire_cnt_q + {31'b0, inst_retire};
        if (clear_cnt) begin
            cycle_cnt_d  = '0;
            retire_cnt_d = '0;
        end

        // A simultaneous store wins, so the load is dropped entirely.
        ld_valid_d = req_re & ~req_we;
        region_d   = REGION_NONE;
        if (is_ram) begin
            region_d = REGION_RAM;
        end else if (hit_cycle || hit_retire) begin
            region_d = REGION_CNT;
        end
        offset_d  = req_addr[1:0];
        st_mis_d  = req_we & st_mis;
        cnt_val_d = hit_retire ? retire_cnt_q : cycle_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            ld_valid_q   <= 1'b0;
            region_q     <= REGION_NONE;
            offset_q     <= 2'b00;
            st_mis_q     <= 1'b0;
            cnt_val_q    <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            ld_valid_q   <= ld_valid_d;
            region_q     <= region_d;
            offset_q     <= offset_d;
            st_mis_q     <= st_mis_d;
            cnt_val_q    <= cnt_val_d;
        end
    end

    // Write and read share the edge; a read returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
        ram_word_q <= reset ? mem[word_idx] : 32'd0;
    end

    logic        ld_mis;
    logic [31:0] src_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    always_comb begin
        ld_mis = 1'b0;
        case (ld_size)
            3'b010:         ld_mis = |offset_q;
            3'b001, 3'b101: ld_mis = offset_q[0];
            default:        ld_mis = 1'b0;
        endcase
        // Counters only answer whole-word loads; narrower accesses are treated as misaligned.
        if (region_q == REGION_CNT && ld_size != 3'b010) begin
            ld_mis = 1'b1;
        end

        src_word = 32'd0;
        case (region_q)
            REGION_RAM: src_word = ram_word_q;
            REGION_CNT: src_word = cnt_val_q;
            default:    src_word = 32'd0;
        endcase

        byte_sel = src_word[{offset_q, 3'b000} +: 8];
        half_sel = src_word[{offset_q[1], 4'b0000} +: 16];

        ext_data = 32'd0;
        case (ld_size)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  ext_data = src_word;
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = 32'd0;
        endcase

        rdata      = (reset && ld_valid_q && !ld_mis) ? ext_data : 32'd0;
        misaligned = reset & (st_mis_q | (ld_valid_q & ld_mis));
    end

endmodule
